pong_game_ctrl: RTL and testbench

//  Top-level Pong game sequencer: the initiator side of the countdown-timer interface (timer_start/timer_tick/timer_up).

---
 rtl/pong_game_ctrl_pkg.sv | 11 +
 rtl/pong_game_ctrl_bcd2_counter.sv | 20 ++
 rtl/pong_game_ctrl.sv | 93 +++++++++
 tb/tb_pong_game_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/pong_game_ctrl_pkg.sv
// pong_game_ctrl_pkg: state codes and field widths shared by the Pong sequencer, text and graphics blocks.
package pong_game_ctrl_pkg;
    localparam int DIGIT_W = 4;
    localparam int BALLS_W = 2;
    typedef enum logic [1:0] {
        NEWGAME = 2'd0,
        PLAY    = 2'd1,
        NEWBALL = 2'd2,
        OVER    = 2'd3
    } state_t;
endpackage

// File: rtl/pong_game_ctrl_bcd2_counter.sv
// bcd2_counter: two-digit BCD up-counter with synchronous clear, wrapping 99 -> 00.
module bcd2_counter
    import pong_game_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               clr,
    input  logic               inc,
    output logic [DIGIT_W-1:0] d1,
    output logic [DIGIT_W-1:0] d0
);
    always_ff @(posedge clk) begin
        if (clr) begin
            d1 <= '0;
            d0 <= '0;
        end else if (inc) begin
            d0 <= (d0 == 4'd9) ? 4'd0 : d0 + 4'd1;
            d1 <= (d0 != 4'd9) ? d1 : (d1 == 4'd9) ? 4'd0 : d1 + 4'd1;
        end
    end
endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: Pong game sequencer driving the countdown timer, ball count and BCD score.
module pong_game_ctrl
    import pong_game_ctrl_pkg::*;
#(
    parameter int BALLS    = 3,
    parameter int TICK_DIV = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         btn,
    input  logic               hit,
    input  logic               miss,
    input  logic               refresh_tick,
    input  logic               timer_up,
    output logic               timer_start,
    output logic               timer_tick,
    output logic               graph_still,
    output logic [1:0]         game_state,
    output logic [BALLS_W-1:0] balls_left,
    output logic [DIGIT_W-1:0] score_d1,
    output logic [DIGIT_W-1:0] score_d0
);
    localparam logic [BALLS_W-1:0] BALLS_N = BALLS_W'(BALLS);
    localparam logic [3:0]         DIV_MAX = 4'(TICK_DIV - 1);

    state_t     state, state_next;
    logic       armed;
    logic [3:0] div_cnt;
    logic       pressed, start_next, still_next;

    assign pressed    = |btn;
    assign game_state = state;

    always_ff @(posedge clk) begin
        if (reset) state <= NEWGAME;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            NEWGAME: state_next = pressed ? PLAY : NEWGAME;
            PLAY:    state_next = !miss ? PLAY : (balls_left == '0) ? OVER : NEWBALL;
            NEWBALL: state_next = (armed && timer_up && pressed) ? PLAY : NEWBALL;
            OVER:    state_next = (armed && timer_up) ? NEWGAME : OVER;
            default: state_next = NEWGAME;
        endcase
    end

    always_comb begin
        start_next = (state == PLAY) && miss;
        still_next = state_next != PLAY;
    end

    // armed drops for exactly the first cycle after any state change, masking a stale timer_up.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_start <= 1'b0;
            graph_still <= 1'b1;
            armed       <= 1'b0;
            balls_left  <= BALLS_N;
        end else begin
            timer_start <= start_next;
            graph_still <= still_next;
            armed       <= state_next == state;
            if (state_next == NEWGAME)
                balls_left <= BALLS_N;
            else if (state == NEWGAME)
                balls_left <= BALLS_N - 1'b1;
            else if (start_next && balls_left != '0)
                balls_left <= balls_left - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt    <= '0;
            timer_tick <= 1'b0;
        end else begin
            timer_tick <= refresh_tick && (div_cnt == DIV_MAX);
            if (refresh_tick)
                div_cnt <= (div_cnt == DIV_MAX) ? 4'd0 : div_cnt + 4'd1;
        end
    end

    bcd2_counter u_score (
        .clk (clk),
        .clr (reset || state_next == NEWGAME),
        .inc (state == PLAY && hit),
        .d1  (score_d1),
        .d0  (score_d0)
    );
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed checks of the Pong sequencer, including a TICK_DIV=3 instance.
module tb_pong_game_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] btn = 2'b00;
    logic       hit = 1'b0, miss = 1'b0, refresh_tick = 1'b0, timer_up = 1'b0;
    logic       timer_start, timer_tick, graph_still;
    logic [1:0] game_state, balls_left;
    logic [3:0] score_d1, score_d0;
    logic       u3_start, u3_tick, u3_still;
    logic [1:0] u3_state, u3_balls;
    logic [3:0] u3_d1, u3_d0;
    int         total = 0, bad = 0;

    always #5 clk = ~clk;

    pong_game_ctrl #(.BALLS(3), .TICK_DIV(1)) dut (
        .clk(clk), .reset(reset), .btn(btn), .hit(hit), .miss(miss),
        .refresh_tick(refresh_tick), .timer_up(timer_up),
        .timer_start(timer_start), .timer_tick(timer_tick), .graph_still(graph_still),
        .game_state(game_state), .balls_left(balls_left),
        .score_d1(score_d1), .score_d0(score_d0)
    );

    pong_game_ctrl #(.BALLS(3), .TICK_DIV(3)) dut3 (
        .clk(clk), .reset(reset), .btn(btn), .hit(hit), .miss(miss),
        .refresh_tick(refresh_tick), .timer_up(timer_up),
        .timer_start(u3_start), .timer_tick(u3_tick), .graph_still(u3_still),
        .game_state(u3_state), .balls_left(u3_balls),
        .score_d1(u3_d1), .score_d0(u3_d0)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_hits(input int n);
        for (int i = 0; i < n; i++) begin
            hit = 1'b1;
            step();
            hit = 1'b0;
            step();
        end
    endtask

    initial begin
        step();
        reset = 1'b0;
        chk("rst_state", 8'(game_state), 8'd0);
        chk("rst_still", 8'(graph_still), 8'd1);
        chk("rst_balls", 8'(balls_left), 8'd3);
        chk("rst_score", {score_d1, score_d0}, 8'h00);
        chk("rst_start", 8'(timer_start), 8'd0);
        btn = 2'b01;
        step();
        btn = 2'b00;
        chk("start_state", 8'(game_state), 8'd1);
        chk("start_balls", 8'(balls_left), 8'd2);
        chk("start_still", 8'(graph_still), 8'd0);
        pulse_hits(12);
        chk("score12", {score_d1, score_d0}, 8'h12);
        miss = 1'b1;
        step();
        miss = 1'b0;
        chk("miss1_state", 8'(game_state), 8'd2);
        chk("miss1_start", 8'(timer_start), 8'd1);
        chk("miss1_balls", 8'(balls_left), 8'd1);
        chk("miss1_still", 8'(graph_still), 8'd1);
        timer_up = 1'b1;
        btn = 2'b10;
        step();
        chk("nb_unarmed", 8'(game_state), 8'd2);
        chk("nb_start_off", 8'(timer_start), 8'd0);
        step();
        chk("nb_resume", 8'(game_state), 8'd1);
        chk("nb_resume_still", 8'(graph_still), 8'd0);
        timer_up = 1'b0;
        btn = 2'b00;
        step();
        miss = 1'b1;
        step();
        miss = 1'b0;
        chk("miss2_state", 8'(game_state), 8'd2);
        chk("miss2_balls", 8'(balls_left), 8'd0);
        hit = 1'b1;
        step();
        hit = 1'b0;
        chk("nb_hit_ignored", {score_d1, score_d0}, 8'h12);
        btn = 2'b01;
        step();
        chk("nb_btn_only", 8'(game_state), 8'd2);
        btn = 2'b00;
        timer_up = 1'b1;
        step();
        chk("nb_up_only", 8'(game_state), 8'd2);
        btn = 2'b01;
        step();
        btn = 2'b00;
        timer_up = 1'b0;
        chk("nb_resume2", 8'(game_state), 8'd1);
        pulse_hits(87);
        chk("score99", {score_d1, score_d0}, 8'h99);
        hit = 1'b1;
        miss = 1'b1;
        step();
        hit = 1'b0;
        miss = 1'b0;
        chk("wrap_score", {score_d1, score_d0}, 8'h00);
        chk("over_state", 8'(game_state), 8'd3);
        chk("over_start", 8'(timer_start), 8'd1);
        chk("over_balls", 8'(balls_left), 8'd0);
        timer_up = 1'b1;
        step();
        chk("over_unarmed", 8'(game_state), 8'd3);
        chk("over_start_off", 8'(timer_start), 8'd0);
        step();
        timer_up = 1'b0;
        chk("over_done", 8'(game_state), 8'd0);
        chk("over_balls_rst", 8'(balls_left), 8'd3);
        chk("over_score", {score_d1, score_d0}, 8'h00);
        btn = 2'b10;
        step();
        btn = 2'b00;
        pulse_hits(3);
        miss = 1'b1;
        step();
        miss = 1'b0;
        chk("pre_rst_state", 8'(game_state), 8'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_state", 8'(game_state), 8'd0);
        chk("mid_rst_start", 8'(timer_start), 8'd0);
        chk("mid_rst_still", 8'(graph_still), 8'd1);
        chk("mid_rst_balls", 8'(balls_left), 8'd3);
        chk("mid_rst_score", {score_d1, score_d0}, 8'h00);
        for (int i = 0; i < 60; i++) begin
            refresh_tick = (i % 10 == 0);
            step();
            refresh_tick = 1'b0;
            chk($sformatf("tick1_%0d", i), 8'(timer_tick), 8'(i % 10 == 0));
            chk($sformatf("tick3_%0d", i), 8'(u3_tick), 8'(i == 20 || i == 50));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
